// File: rtl/ms_display_scanner_if.sv
// Bus bundle for the millisecond display scanner.
// Master drives load requests; slave returns status, BCD and segment drive.
interface ms_display_scanner_if;
    logic [16:0] value_in;
    logic        load;
    logic        busy;
    logic        bcd_valid;
    logic [23:0] bcd_out;
    logic [7:0]  seg;
    logic [5:0]  dig_sel;

    modport master (
        output value_in,
        output load,
        input  busy,
        input  bcd_valid,
        input  bcd_out,
        input  seg,
        input  dig_sel
    );

    modport slave (
        input  value_in,
        input  load,
        output busy,
        output bcd_valid,
        output bcd_out,
        output seg,
        output dig_sel
    );
endinterface

// File: rtl/ms_display_scanner.sv
// Millisecond count to six BCD digits (serial double-dabble) and a
// multiplexed "SSS.mmm" seven-segment scan with leading-zero blanking.
module ms_display_scanner #(
    parameter int SCAN_DIV = 100000,
    parameter int DP_POS   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    ms_display_scanner_if.slave  bus
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [2:0]    DP_IDX   = 3'(DP_POS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t        state_q;
    logic [16:0]   sh_q;
    logic [23:0]   acc_q;
    logic [23:0]   acc_d;
    logic [4:0]    iter_q;
    logic          busy_q;
    logic          bcd_valid_q;
    logic [23:0]   bcd_out_q;
    logic [23:0]   disp_q;
    logic [23:0]   disp_d;

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic [2:0]    idx_q;
    logic [2:0]    idx_d;
    logic [5:0]    sel_q;
    logic [5:0]    sel_d;
    logic [7:0]    seg_q;
    logic [7:0]    seg_d;
    logic [5:0]    blank;
    logic          div_wrap;

    // Segment pattern {A..G} for one BCD digit.
    function automatic logic [6:0] enc7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Double-dabble correction: add 3 to every nibble of 5 or more.
    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < 6; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_d[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Display content as it will be after this edge, so seg never lags it.
    always_comb begin
        disp_d = disp_q;
        if (state_q == S_COMMIT) begin
            disp_d = acc_q;
        end
    end

    // Conversion FSM: load, 17 shift iterations, then commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            acc_q       <= '0;
            iter_q      <= '0;
            busy_q      <= 1'b0;
            bcd_valid_q <= 1'b0;
            bcd_out_q   <= '0;
            disp_q      <= '0;
        end else begin
            bcd_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.load) begin
                        sh_q    <= bus.value_in;
                        acc_q   <= '0;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {acc_q, sh_q} <= {acc_d[22:0], sh_q, 1'b0};
                    iter_q        <= iter_q + 5'd1;
                    if (iter_q == 5'd16) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    bcd_out_q   <= acc_q;
                    disp_q      <= disp_d;
                    bcd_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Leading-zero blanking above the decimal-point digit.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank      = '0;
        for (int k = 5; k >= 0; k--) begin
            zero_above = zero_above && (disp_d[4*k +: 4] == 4'd0);
            blank[k]   = zero_above && (k > DP_POS);
        end
    end

    // Scan divider, digit index rotation and next segment byte.
    always_comb begin
        logic [3:0] dig;
        logic       blk;
        div_wrap = (div_q == DIV_LAST);
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        idx_d    = idx_q;
        sel_d    = sel_q;
        if (div_wrap) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            sel_d = {sel_q[4:0], sel_q[5]};
        end
        dig = 4'd0;
        blk = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (idx_d == 3'(k)) begin
                dig = disp_d[4*k +: 4];
                blk = blank[k];
            end
        end
        seg_d = {blk ? 7'b0000000 : enc7(dig), idx_d == DP_IDX};
    end

    // Scan registers; seg and dig_sel update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
            sel_q <= 6'b000001;
            seg_q <= '0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.bcd_valid = bcd_valid_q;
    assign bus.bcd_out   = bcd_out_q;
    assign bus.seg       = seg_q;
    assign bus.dig_sel   = sel_q;

endmodule

// File: tb/tb_ms_display_scanner.sv
// Directed bench for ms_display_scanner with a short scan period.
// Expected patterns are hand-derived from the segment table.
module tb_ms_display_scanner;

    localparam int SD = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0] got_seg [6];
    logic       sel_bad;

    ms_display_scanner_if bus ();

    ms_display_scanner #(
        .SCAN_DIV(SD),
        .DP_POS  (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record the segment byte seen for every digit over one full scan.
    task automatic capture();
        for (int d = 0; d < 6; d++) got_seg[d] = 8'hxx;
        sel_bad = 1'b0;
        for (int c = 0; c < 6 * SD; c++) begin
            tick();
            if ($countones(bus.dig_sel) != 1) sel_bad = 1'b1;
            for (int d = 0; d < 6; d++) begin
                if (bus.dig_sel[d]) got_seg[d] = bus.seg;
            end
        end
    endtask

    // Issue a single-cycle load at the next edge.
    task automatic do_load(input logic [16:0] v);
        bus.value_in = v;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    // Bounded wait for the commit pulse.
    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (bus.bcd_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (bus.bcd_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout bcd_valid=%b required 1", name, bus.bcd_valid);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_status busy=%b valid=%b required 0 0",
                     bus.busy, bus.bcd_valid);
        end
        checks++;
        if (bus.bcd_out !== 24'h0) begin
            errors++;
            $display("FAIL reset_bcd got %h required 000000", bus.bcd_out);
        end
        checks++;
        if (bus.dig_sel !== 6'b000001 || bus.seg !== 8'h00) begin
            errors++;
            $display("FAIL reset_scan sel=%b seg=%b required 000001 00000000",
                     bus.dig_sel, bus.seg);
        end
    endtask

    task automatic test_max();
        logic [7:0] exp [6];
        exp = '{8'b01100000, 8'b11100000, 8'b11111100,
                8'b01100001, 8'b11110010, 8'b01100000};
        do_load(17'd131071);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL max_busy_start got %b required 1", bus.busy);
        end
        for (int e = 1; e <= 17; e++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b1 || bus.bcd_valid !== 1'b0) begin
                errors++;
                $display("FAIL max_busy_N+%0d busy=%b valid=%b required 1 0",
                         e, bus.busy, bus.bcd_valid);
            end
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.bcd_valid !== 1'b1) begin
            errors++;
            $display("FAIL max_commit busy=%b valid=%b required 0 1",
                     bus.busy, bus.bcd_valid);
        end
        checks++;
        if (bus.bcd_out !== 24'h131071) begin
            errors++;
            $display("FAIL max_bcd got %h required 131071", bus.bcd_out);
        end
        tick();
        checks++;
        if (bus.bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL max_pulse_width got %b required 0", bus.bcd_valid);
        end
        capture();
        for (int d = 0; d < 6; d++) begin
            checks++;
            if (got_seg[d] !== exp[d]) begin
                errors++;
                $display("FAIL max_seg%0d got %b required %b", d, got_seg[d], exp[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [6];
        exp = '{8'b11111100, 8'b11111100, 8'b11111100,
                8'b11111101, 8'b00000000, 8'b00000000};
        tick();
        tick();
        do_load(17'd42);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.bcd_out !== 24'h0 ||
            bus.dig_sel !== 6'b000001 || bus.seg !== 8'h00) begin
            errors++;
            $display("FAIL midreset_async busy=%b bcd=%h sel=%b seg=%b required 0 000000 000001 00000000",
                     bus.busy, bus.bcd_out, bus.dig_sel, bus.seg);
        end
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.dig_sel !== 6'b000001 || bus.seg !== 8'h00) begin
            errors++;
            $display("FAIL midreset_release busy=%b sel=%b seg=%b required 0 000001 00000000",
                     bus.busy, bus.dig_sel, bus.seg);
        end
        capture();
        for (int d = 0; d < 6; d++) begin
            checks++;
            if (got_seg[d] !== exp[d]) begin
                errors++;
                $display("FAIL midreset_seg%0d got %b required %b", d, got_seg[d], exp[d]);
            end
        end
        checks++;
        if (bus.bcd_out !== 24'h0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle bcd=%h busy=%b required 000000 0",
                     bus.bcd_out, bus.busy);
        end
    endtask

    task automatic test_five();
        logic [7:0] exp [6];
        exp = '{8'b10110110, 8'b11111100, 8'b11111100,
                8'b11111101, 8'b00000000, 8'b00000000};
        do_load(17'd5);
        wait_valid("five");
        checks++;
        if (bus.bcd_out !== 24'h000005) begin
            errors++;
            $display("FAIL five_bcd got %h required 000005", bus.bcd_out);
        end
        capture();
        for (int d = 0; d < 6; d++) begin
            checks++;
            if (got_seg[d] !== exp[d]) begin
                errors++;
                $display("FAIL five_seg%0d got %b required %b", d, got_seg[d], exp[d]);
            end
        end
    endtask

    task automatic test_100000();
        logic [7:0] exp [6];
        logic [5:0] s0;
        logic [5:0] es;
        int         n;
        exp = '{8'b11111100, 8'b11111100, 8'b11111100,
                8'b11111101, 8'b11111100, 8'b01100000};
        do_load(17'd100000);
        wait_valid("k100");
        checks++;
        if (bus.bcd_out !== 24'h100000) begin
            errors++;
            $display("FAIL k100_bcd got %h required 100000", bus.bcd_out);
        end
        capture();
        for (int d = 0; d < 6; d++) begin
            checks++;
            if (got_seg[d] !== exp[d]) begin
                errors++;
                $display("FAIL k100_seg%0d got %b required %b", d, got_seg[d], exp[d]);
            end
        end
        checks++;
        if (sel_bad !== 1'b0) begin
            errors++;
            $display("FAIL k100_onehot got non-one-hot dig_sel required one-hot");
        end
        s0 = bus.dig_sel;
        n  = 0;
        while (bus.dig_sel === s0 && n < 2 * SD) begin
            tick();
            n++;
        end
        s0 = bus.dig_sel;
        for (int c = 0; c < 6 * SD; c++) begin
            es = s0;
            for (int r = 0; r < c / SD; r++) es = {es[4:0], es[5]};
            checks++;
            if (bus.dig_sel !== es) begin
                errors++;
                $display("FAIL k100_rotate_c%0d got %b required %b", c, bus.dig_sel, es);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_load(17'd42);
        for (int e = 1; e <= 4; e++) tick();
        do_load(17'd777);
        for (int e = 6; e <= 17; e++) tick();
        bus.value_in = 17'd888;
        bus.load     = 1'b1;
        tick();
        checks++;
        if (bus.bcd_valid !== 1'b1 || bus.bcd_out !== 24'h000042 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first valid=%b bcd=%h busy=%b required 1 000042 0",
                     bus.bcd_valid, bus.bcd_out, bus.busy);
        end
        do_load(17'd999);
        checks++;
        if (bus.busy !== 1'b1 || bus.bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept busy=%b valid=%b required 1 0",
                     bus.busy, bus.bcd_valid);
        end
        for (int e = 20; e <= 36; e++) tick();
        checks++;
        if (bus.bcd_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_N36 valid=%b busy=%b required 0 1",
                     bus.bcd_valid, bus.busy);
        end
        tick();
        checks++;
        if (bus.bcd_valid !== 1'b1 || bus.bcd_out !== 24'h000999) begin
            errors++;
            $display("FAIL b2b_second valid=%b bcd=%h required 1 000999",
                     bus.bcd_valid, bus.bcd_out);
        end
    endtask

    task automatic test_stability();
        logic [7:0] e1 [6];
        logic [7:0] e2 [6];
        e1 = '{8'b01100110, 8'b11110010, 8'b11011010,
               8'b01100001, 8'b00000000, 8'b00000000};
        e2 = '{8'b11100000, 8'b11100000, 8'b11100000,
               8'b11100001, 8'b00000000, 8'b00000000};
        do_load(17'd1234);
        wait_valid("stab1234");
        capture();
        for (int d = 0; d < 6; d++) begin
            checks++;
            if (got_seg[d] !== e1[d]) begin
                errors++;
                $display("FAIL stab1234_seg%0d got %b required %b", d, got_seg[d], e1[d]);
            end
        end
        do_load(17'd7777);
        for (int e = 1; e <= 17; e++) begin
            for (int d = 0; d < 6; d++) begin
                if (bus.dig_sel[d]) begin
                    checks++;
                    if (bus.seg !== e1[d]) begin
                        errors++;
                        $display("FAIL stab_hold_N+%0d got %b required %b",
                                 e, bus.seg, e1[d]);
                    end
                end
            end
            tick();
        end
        tick();
        checks++;
        if (bus.bcd_valid !== 1'b1 || bus.bcd_out !== 24'h007777) begin
            errors++;
            $display("FAIL stab7777_commit valid=%b bcd=%h required 1 007777",
                     bus.bcd_valid, bus.bcd_out);
        end
        capture();
        for (int d = 0; d < 6; d++) begin
            checks++;
            if (got_seg[d] !== e2[d]) begin
                errors++;
                $display("FAIL stab7777_seg%0d got %b required %b", d, got_seg[d], e2[d]);
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.value_in = '0;
        #1;
        test_reset();
        #22;
        rst = 1'b0;
        tick();
        test_max();
        test_reset_mid();
        test_five();
        test_100000();
        test_back_to_back();
        tick();
        test_stability();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ms_display_scanner.md
Name: ms_display_scanner

Overview:
- Sits directly downstream of the millisecond timer value and directly upstream of the segment pin-mapping stage.
- Converts a 17-bit millisecond count (0–131071) to six BCD digits, using sequential double-dabble at one bit per clock.
- Latches the result and time-multiplexes the six digits onto one segment byte plus a one-hot digit select.
- Display format is "SSS.mmm": decimal point on the seconds-units digit, leading zeros blanked.

Parameters:
- SCAN_DIV, 100000, clock cycles each digit stays selected (minimum 2).
- DP_POS, 3, digit index carrying the decimal point. This is also the highest digit that is never blanked.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- value_in  input  17  millisecond count, sampled only on an accepted load
- load  input  1  single-cycle request to convert value_in
- busy  output  1  high while a conversion is in progress
- bcd_valid  output  1  one-cycle pulse when bcd_out and the display register update
- bcd_out  output  24  six BCD digits; [3:0] = digit 0 (ms units) ... [23:20] = digit 5 (hundreds of seconds)
- seg  output  8  segment byte for the selected digit, bit order {A,B,C,D,E,F,G,DP}, active-high
- dig_sel  output  6  one-hot digit enable; bit k selects digit k

Behaviour:
- Reset (asynchronous, active-high) sets:
  - busy=0, bcd_valid=0, bcd_out=0, display register=0;
  - scan divider=0, digit index=0, dig_sel=6'b000001, seg=8'b00000000;
  - FSM=IDLE.
- A conversion aborted by reset is discarded. The display register is not partially updated.
- FSM states are IDLE, SHIFT, COMMIT.
  - IDLE: load=1 at edge N loads the shift register with value_in and clears the BCD accumulator. Set busy=1, iter=0, go to SHIFT.
  - SHIFT: each edge first adds 3 to every accumulator nibble ≥5, then shifts {accum,shreg} left by 1. Edges N+1..N+17 run the 17 iterations. After iteration 17, go to COMMIT.
  - COMMIT, edge N+18: bcd_out and the display register take the accumulator. bcd_valid=1 for that single cycle, busy=0, return to IDLE.
- load while busy is ignored. There is no queueing.
- load in the same cycle as the COMMIT edge is also ignored. It is accepted from IDLE on the next cycle.
- Width and range rules:
  - The 24-bit accumulator is sufficient for the full range.
  - 131071 → bcd_out=24'h131071.
  - No digit exceeds 9, and no overflow is possible.
- Scan:
  - The divider counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - On wrap, the digit index advances 0→1→…→5→0 and dig_sel rotates left to match.
  - dig_sel is always exactly one-hot, including out of reset.
  - seg is registered, so it changes on the same edge as dig_sel. There is no skew between them.
  - seg always reflects the display register. A conversion in progress never alters the display.
- Segment encoding {A..G}, with DP=0 in these codes:
  - 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110
  - 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110
- Decimal point: seg[0]=1 when the digit index = DP_POS. This applies whether or not the digit is blanked; DP_POS is never blanked anyway.
- Blanking: digit k > DP_POS outputs seg=0 if it and all higher digits are zero.
  - Example: value 5 displays as "0.005" with digits 4 and 5 dark.
  - Example: value 100000 displays digit 5=1, digit 4=0.

Test Plan:
- Reset mid-scan and mid-SHIFT, then release → dig_sel=000001, seg=0, busy=0, bcd_out=0; with no load, the scan shows "0." on digit 3 and all other non-blank digits show ZERO.
- load with value_in=131071 at edge N → busy high N..N+17; bcd_valid pulses one cycle after edge N+18; bcd_out=24'h131071; the digit 3 seg word is 01100000 with DP set to 1, i.e. 01100001.
- value_in=5, SCAN_DIV=4 → the full 24-cycle scan gives digit0=10110110, digit1=11111100, digit2=11111100, digit3=11111101, digit4=0, digit5=0.
- value_in=100000 → digits 5..0 = 1,0,0,0,0,0; digit 4 shows ZERO, not blanked; dig_sel is one-hot and advances every SCAN_DIV cycles.
- Second load at edges N+5 and N+18 during a conversion of 42 → both ignored, bcd_out=24'h000042; a new load of 999 at N+19 gives bcd_out=24'h000999 at N+37.
- Display stability: load 7777 while the display shows 1234 → seg keeps the 1234 patterns until the COMMIT edge, then changes to the 7777 patterns on the next scan.
